pulse_gen: RTL and testbench

Programmable pulse generator: the transmit-side counterpart of the edge2 edge detector. Each single-cycle `trig` strobe becomes a clean registered high pulse of `high_len` cycles followed by a mandatory low gap of `low_len` cycles. Consecutive pulses are therefore always separated, so a downstream edge detector sees exactly one rising edge per trigger. Triggers that arrive while a pulse is in progress are queued in a saturating pending counter, and queue overflow is flagged.

---
 rtl/pulse_gen.sv | 111 +++++++++++
 tb/tb_pulse_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Programmable pulse generator: each trigger yields a high pulse followed by a mandatory low gap.
// Triggers arriving mid-pulse are queued in a saturating counter; drops set a sticky ovf flag.
module pulse_gen #(
  parameter int unsigned W  = 8,
  parameter int unsigned QW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic [W-1:0]  high_len,
  input  logic [W-1:0]  low_len,
  input  logic          clr_ovf,
  output logic          out,
  output logic          busy,
  output logic [QW-1:0] pending,
  output logic          ovf
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [W-1:0]  One     = W'(1);
  localparam logic [QW-1:0] PendMax = '1;

  state_e        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  glen_q, glen_d;
  logic [QW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  hlen_eff, glen_eff;
  logic [QW:0]   eff;
  logic          ovf_set;

  assign hlen_eff = (high_len == '0) ? One : high_len;
  assign glen_eff = (low_len == '0) ? One : low_len;
  assign eff      = {1'b0, pend_q} + {{QW{1'b0}}, trig};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glen_d  = glen_q;
    pend_d  = pend_q;
    ovf_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StHigh;
          cnt_d   = hlen_eff;
          glen_d  = glen_eff;
        end
      end
      StHigh: begin
        if (cnt_q == One) begin
          state_d = StLow;
          cnt_d   = glen_q;
        end else begin
          cnt_d = cnt_q - One;
        end
        if (trig) begin
          if (pend_q != PendMax) pend_d = pend_q + QW'(1);
          else                   ovf_set = 1'b1;
        end
      end
      StLow: begin
        if (cnt_q == One) begin
          // Last gap cycle: a trigger here is consumed by the dequeue, never dropped.
          if (eff != '0) begin
            state_d = StHigh;
            cnt_d   = hlen_eff;
            glen_d  = glen_eff;
            pend_d  = QW'(eff - (QW+1)'(1));
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - One;
          if (trig) begin
            if (pend_q != PendMax) pend_d = pend_q + QW'(1);
            else                   ovf_set = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      glen_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      glen_q  <= glen_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out     = (state_q == StHigh);
  assign busy    = (state_q != StIdle);
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: a position-based reference model feeds a scoreboard queue,
// plus directed checks of the documented waveforms.
module tb_pulse_gen;

  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst, trig, clr_ovf;
  logic [7:0] high_len, low_len;
  logic       out, busy, ovf;
  logic [1:0] pending;

  always #5 clk = ~clk;

  pulse_gen #(.W(8), .QW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .trig     (trig),
    .high_len (high_len),
    .low_len  (low_len),
    .clr_ovf  (clr_ovf),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .ovf      (ovf)
  );

  typedef struct {
    logic out;
    logic busy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;
  logic prev_out = 1'b0;

  bit m_active = 0;
  int m_pos = 0, m_h = 1, m_g = 1, m_pend = 0;
  bit m_ovf = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model tracks the position inside the current H+G slot rather than a state machine.
  task automatic model_step();
    int eff;
    bit set;
    set = 0;
    if (rst) begin
      m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    end else begin
      if (!m_active) begin
        if (trig) begin
          m_active = 1; m_pos = 0;
          m_h = (high_len == 0) ? 1 : int'(high_len);
          m_g = (low_len == 0) ? 1 : int'(low_len);
        end
      end else if (m_pos == m_h + m_g - 1) begin
        eff = m_pend + int'(trig);
        if (eff > 0) begin
          m_pos = 0; m_pend = eff - 1;
          m_h = (high_len == 0) ? 1 : int'(high_len);
          m_g = (low_len == 0) ? 1 : int'(low_len);
        end else begin
          m_active = 0;
        end
      end else begin
        m_pos++;
        if (trig) begin
          if (m_pend < PMAX) m_pend++;
          else set = 1;
        end
      end
      if (set) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.out  = m_active && (m_pos < m_h);
    e.busy = m_active;
    e.pend = m_pend;
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("out", out, e.out);
    check_eq("busy", busy, e.busy);
    check_eq("pending", pending, e.pend);
    check_eq("ovf", ovf, e.ovf);
    if (out && !prev_out) pulses++;
    prev_out = out;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      step();
    end
    check_eq("drain_busy", busy, 0);
  endtask

  logic [9:0] ov;
  logic [5:0] bv;

  initial begin
    rst = 1; trig = 0; clr_ovf = 0; high_len = 0; low_len = 0;
    step(); step();
    rst = 0;
    check_eq("rst_out", out, 0);
    check_eq("rst_pending", pending, 0);

    // Single pulse: H=3, G=2
    high_len = 3; low_len = 2;
    trig = 1; step(); ov[5] = out; bv[5] = busy;
    trig = 0;
    for (int i = 4; i >= 0; i--) begin step(); ov[i] = out; bv[i] = busy; end
    check_eq("single_out", ov[5:0], 6'b111000);
    check_eq("single_busy", bv, 6'b111110);

    // Queue: trig held three cycles, H=2, G=1
    high_len = 2; low_len = 1; pulses = 0;
    for (int i = 9; i >= 0; i--) begin
      trig = (i >= 7);
      step();
      ov[i] = out;
      if (i == 6) check_eq("queue_pend_c4", pending, 1);
      if (i == 3) check_eq("queue_pend_c7", pending, 0);
    end
    trig = 0;
    check_eq("queue_out", ov, 10'b1101101100);
    check_eq("queue_busy_end", busy, 0);
    check_eq("queue_pulses", pulses, 3);

    // Overflow: one start trigger plus four during a long high phase
    high_len = 10; low_len = 1; pulses = 0;
    trig = 1;
    for (int i = 0; i < 5; i++) step();
    trig = 0;
    check_eq("ovf_pend_sat", pending, 3);
    check_eq("ovf_set", ovf, 1);
    clr_ovf = 1; step(); clr_ovf = 0;
    check_eq("ovf_cleared", ovf, 0);
    drain();
    check_eq("ovf_pulses", pulses, 4);

    // Zero lengths treated as 1
    high_len = 0; low_len = 0;
    trig = 1; step(); ov[3] = out;
    step(); ov[2] = out;
    trig = 0;
    step(); ov[1] = out;
    step(); ov[0] = out;
    check_eq("zero_out", ov[3:0], 4'b1010);
    drain();

    // Trigger on the final gap cycle with nothing queued
    high_len = 2; low_len = 2;
    trig = 1; step();
    trig = 0; step(); step(); step();
    trig = 1; step();
    trig = 0;
    check_eq("final_low_out", out, 1);
    check_eq("final_low_pend", pending, 0);
    drain();

    // Reset mid-pulse with two queued
    high_len = 10; low_len = 1;
    trig = 1; step(); step(); step();
    trig = 0;
    check_eq("pre_rst_pend", pending, 2);
    rst = 1; step(); rst = 0;
    check_eq("mid_rst_out", out, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_pend", pending, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) step();
    check_eq("post_rst_pulses", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
